// File: rtl/tx_shaper.sv
// rtl/tx_shaper.sv - PRBS9 BPSK pulse-shaping transmitter; macro TX_SHAPER_SAT_EN saturates the output
module tx_shaper #(
    parameter int                              OS       = 4,
    parameter int                              SPAN     = 6,
    parameter int                              NB_COEFF = 8,
    parameter logic [SPAN*OS*NB_COEFF-1:0]     COEFFS   = {(SPAN*OS){8'h10}},
    parameter int                              NB_OUT   = 8,
    parameter logic [8:0]                      SEED     = 9'h1FF
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [NB_OUT-1:0] o_sample,
    output logic              o_valid,
    output logic              o_bit,
    output logic              o_sym_strobe
);

    localparam int NB_PH  = $clog2(OS);
    localparam int NB_ACC = NB_COEFF + $clog2(SPAN) + 1;
    localparam int SHR    = (NB_COEFF > NB_OUT) ? NB_COEFF - NB_OUT : 0;
    localparam int SHL    = (NB_OUT > NB_COEFF) ? NB_OUT - NB_COEFF : 0;
    localparam int NB_AL  = NB_ACC + SHL;
    localparam logic signed [NB_AL-1:0] MAXV = NB_AL'((64'sd1 <<< (NB_OUT - 1)) - 64'sd1);
    localparam logic signed [NB_AL-1:0] MINV = ~MAXV;
`ifdef TX_SHAPER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [8:0]              r_prbs;
    logic [SPAN-1:0]         r_nz;
    logic [SPAN-1:0]         r_sign;
    logic [NB_PH-1:0]        r_phase;
    logic [NB_OUT-1:0]       r_sample;
    logic                    r_valid;
    logic                    r_bit;
    logic                    r_strobe;

    logic                    w_sym_tick;
    logic signed [NB_COEFF-1:0] w_tap;
    logic signed [NB_ACC-1:0] w_sum;
    logic signed [NB_AL-1:0]  w_al;
    logic [NB_OUT-1:0]       w_out;

    assign w_sym_tick = i_en && (r_phase == '0);

    // Polyphase dot product over the pre-update delay line
    always_comb begin
        w_sum = '0;
        w_tap = '0;
        for (int k = 0; k < SPAN; k++) begin
            w_tap = $signed(COEFFS[(k*OS + int'(r_phase))*NB_COEFF +: NB_COEFF]);
            if (r_nz[k]) begin
                w_sum = r_sign[k] ? w_sum - NB_ACC'(w_tap) : w_sum + NB_ACC'(w_tap);
            end
        end
    end

    assign w_al = (NB_AL'(w_sum) >>> SHR) <<< SHL;

    always_comb begin
        w_out = w_al[NB_OUT-1:0];
        if (SAT && (w_al > MAXV)) begin
            w_out = MAXV[NB_OUT-1:0];
        end else if (SAT && (w_al < MINV)) begin
            w_out = MINV[NB_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_prbs   <= SEED;
            r_nz     <= '0;
            r_sign   <= '0;
            r_phase  <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_bit    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_valid  <= i_en;
            r_strobe <= w_sym_tick;
            if (i_en) begin
                r_sample <= w_out;
                r_phase  <= (r_phase == NB_PH'(OS - 1)) ? '0 : r_phase + 1'b1;
            end
            if (w_sym_tick) begin
                r_prbs <= {r_prbs[7:0], r_prbs[8] ^ r_prbs[4]};
                r_nz   <= {r_nz[SPAN-2:0], 1'b1};
                r_sign <= {r_sign[SPAN-2:0], r_prbs[8]};
                r_bit  <= r_prbs[8];
            end
        end
    end

    assign o_sample     = r_sample;
    assign o_valid      = r_valid;
    assign o_bit        = r_bit;
    assign o_sym_strobe = r_strobe;

endmodule

// File: tb/tb_tx_shaper.sv
// tb/tb_tx_shaper.sv - self-checking bench for tx_shaper against a symbol-level reference model
module tb_tx_shaper;

    localparam int OS    = 4;
    localparam int SPAN  = 6;
    localparam int NTAPS = OS * SPAN;

    function automatic int coef_c(input int i);
        return ((i * 37) % 81) - 40;
    endfunction

    function automatic logic [NTAPS*8-1:0] mk_c();
        logic [NTAPS*8-1:0] v;
        v = '0;
        for (int i = 0; i < NTAPS; i++) v[i*8 +: 8] = 8'(coef_c(i));
        return v;
    endfunction

    localparam logic [NTAPS*8-1:0] COEF_B = {NTAPS{8'h7F}};
    localparam logic [NTAPS*8-1:0] COEF_C = mk_c();

    logic       clk;
    logic       i_reset;
    logic       i_en;
    logic [7:0] smp_a, smp_b, smp_c;
    logic       val_a, val_b, val_c;
    logic       bit_a, bit_b, bit_c;
    logic       stb_a, stb_b, stb_c;

    tx_shaper u_a (.clk(clk), .i_reset(i_reset), .i_en(i_en), .o_sample(smp_a),
                   .o_valid(val_a), .o_bit(bit_a), .o_sym_strobe(stb_a));
    tx_shaper #(.COEFFS(COEF_B)) u_b (.clk(clk), .i_reset(i_reset), .i_en(i_en), .o_sample(smp_b),
                   .o_valid(val_b), .o_bit(bit_b), .o_sym_strobe(stb_b));
    tx_shaper #(.COEFFS(COEF_C)) u_c (.clk(clk), .i_reset(i_reset), .i_en(i_en), .o_sample(smp_c),
                   .o_valid(val_c), .o_bit(bit_c), .o_sym_strobe(stb_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   failures;
    int   n;
    bit   prbs_bits[1024];
    logic [7:0] ea, eb, ec;
    logic ebit, estb;

    function automatic int coef(input int sel, input int i);
        if (sel == 0) return 16;
        if (sel == 1) return 127;
        return coef_c(i);
    endfunction

    // Symbols enter at enabled cycles 0, OS, 2*OS...; sample n sees those strictly before n
    function automatic int model_sum(input int sel, input int idx);
        int ph, cnt, s;
        ph  = idx % OS;
        cnt = (idx + OS - 1) / OS;
        s   = 0;
        for (int k = 0; k < SPAN && k < cnt; k++)
            s += coef(sel, k*OS + ph) * (prbs_bits[cnt-1-k] ? -1 : 1);
        return s;
    endfunction

    function automatic logic [7:0] shape(input int s);
`ifdef TX_SHAPER_SAT_EN
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return 8'(s);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_en    = 1'b1;
        @(posedge clk);
        #1;
        n = 0; ea = 8'h00; eb = 8'h00; ec = 8'h00; ebit = 1'b0; estb = 1'b0;
        chk("rst_sample_a", smp_a, 8'h00);
        chk("rst_sample_b", smp_b, 8'h00);
        chk("rst_valid", val_a, 1'b0);
        chk("rst_bit", bit_a, 1'b0);
        chk("rst_strobe", stb_a, 1'b0);
        i_reset = 1'b1;
    endtask

    task automatic step(input logic en);
        i_en = en;
        @(posedge clk);
        #1;
        estb = 1'b0;
        if (en) begin
            ea = shape(model_sum(0, n));
            eb = shape(model_sum(1, n));
            ec = shape(model_sum(2, n));
            if (n % OS == 0) begin
                ebit = prbs_bits[n / OS];
                estb = 1'b1;
            end
            n++;
        end
        chk("valid", val_a, en);
        chk("sample_a", smp_a, ea);
        chk("sample_b", smp_b, eb);
        chk("sample_c", smp_c, ec);
        chk("bit", bit_a, ebit);
        chk("strobe", stb_a, estb);
    endtask

    initial begin
        logic [8:0] st;
        checks   = 0;
        failures = 0;
        i_reset  = 1'b0;
        i_en     = 1'b0;
        st = 9'h1FF;
        for (int i = 0; i < 1024; i++) begin
            prbs_bits[i] = st[8];
            st = {st[7:0], st[8] ^ st[4]};
        end

        do_reset();
        step(1'b1);
        chk("first_sample_zero", smp_a, 8'h00);
        chk("first_bit_one", bit_a, 1'b1);
        for (int i = 1; i < 22; i++) step(1'b1);
        chk("full_line_a0", smp_a, 8'hA0);
`ifdef TX_SHAPER_SAT_EN
        chk("full_line_sat", smp_b, 8'h80);
`else
        chk("full_line_wrap", smp_b, 8'h06);
`endif
        for (int i = 22; i < 44; i++) step(1'b1);

        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1);
        do_reset();
        step(1'b1);
        chk("restart_sample_zero", smp_a, 8'h00);
        chk("restart_bit_one", bit_a, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1);

        do_reset();
        for (int i = 0; i < 90; i++) step((i % 3) == 0);

        do_reset();
        for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_shaper.md
TX_SHAPER -- requirements
Module: tx_shaper

Interface
REQ-001 The module SHALL have parameter OS, default 4, meaning oversampling factor (samples per symbol, power of two, at least 2).
REQ-002 The module SHALL have parameter SPAN, default 6, meaning filter span in symbols; number of taps NTAPS = SPAN*OS.
REQ-003 The module SHALL have parameter NB_COEFF, default 8, meaning coefficient width, S(8,7).
REQ-004 The module SHALL have parameter COEFFS, default all taps 8'h10, meaning flattened NTAPS*NB_COEFF coefficient vector, tap i at bits [i*NB_COEFF +: NB_COEFF].
REQ-005 The module SHALL have parameter NB_OUT, default 8, meaning output sample width, S(NB_OUT,NB_OUT-1).
REQ-006 The module SHALL have parameter SEED, default 9'h1FF, meaning PRBS9 reset state (nonzero).
REQ-007 The module SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-008 The module SHALL have port i_reset, input, 1 bit: reset, synchronous and active-low.
REQ-009 The module SHALL have port i_en, input, 1 bit: clock enable; one output sample per enabled cycle.
REQ-010 The module SHALL have port o_sample, output, NB_OUT bits: shaped signed transmit sample.
REQ-011 The module SHALL have port o_valid, output, 1 bit: o_sample updated this cycle.
REQ-012 The module SHALL have port o_bit, output, 1 bit: last PRBS bit sent, for downstream BER reference.
REQ-013 The module SHALL have port o_sym_strobe, output, 1 bit: one-cycle pulse when o_bit updates.

Function
REQ-014 The PRBS9 SHALL be Fibonacci x^9+x^5+1: out = s[8], new = s[8]^s[4], s <= {s[7:0],new}; it advances only on enabled cycles with phase==0.
REQ-015 Mapping SHALL be BPSK: bit 0 -> +1, bit 1 -> -1.
REQ-016 The symbol delay line SHALL hold SPAN entries of {nz,sign}; index 0 is newest; on enabled cycles with phase==0 it shifts and entry 0 takes {1, out}.
REQ-017 Phase counter SHALL count 0..OS-1 on enabled cycles and wrap OS-1 -> 0.
REQ-018 Each enabled cycle SHALL compute sum = sum over k of sym[k]*COEFFS[k*OS+phase], using the pre-update delay line and phase; nz=0 contributes 0, sign=1 negates.
REQ-019 Accumulator width SHALL be NB_COEFF+clog2(SPAN)+1 bits, no loss of precision.
REQ-020 o_sample SHALL be the sum aligned to NB_OUT-1 fractional bits (floor of dropped LSBs), registered: valid in the cycle after the enabled cycle.
REQ-021 o_valid SHALL be high exactly in the cycle after each enabled cycle; o_sample SHALL hold its value otherwise.
REQ-022 o_bit SHALL update, and o_sym_strobe SHALL pulse, in the cycle after an enabled phase==0 cycle.
REQ-023 With i_en low, PRBS, delay line, and phase SHALL hold.
REQ-024 With i_en toggling, the output sequence SHALL equal the continuously enabled sequence with gaps.

Reset
REQ-025 When i_reset is low at a rising edge, PRBS SHALL load SEED, every nz SHALL clear, phase SHALL clear to 0, o_sample SHALL clear to 0, o_valid SHALL clear to 0, o_bit SHALL clear to 0, and o_sym_strobe SHALL clear to 0.
REQ-026 Reset SHALL override i_en; a reset mid-symbol SHALL discard the partial symbol and restart at phase 0.

Configuration
REQ-027 With macro TX_SHAPER_SAT_EN defined, sums outside the output range SHALL saturate to 0x7F..F or 0x80..0.
REQ-028 Without TX_SHAPER_SAT_EN, out-of-range sums SHALL wrap by truncation of the high bits.

Verification
REQ-029 Reset, then i_en=1 continuously: the first 9 o_bit values SHALL be 1, and the 10th SHALL be 0; o_sym_strobe SHALL pulse every 4 cycles.
REQ-030 Default COEFFS, i_en=1 from reset: o_sample SHALL be 0 for the first valid sample and SHALL reach 8'hA0 (-0.75) once 6 symbols of -1 are loaded (samples 21..24 onward until a 0 bit enters).
REQ-031 COEFFS all 8'h7F, TX_SHAPER_SAT_EN defined, same stimulus: the full-line sample SHALL be 8'h80; without the macro it SHALL be 8'h06.
REQ-032 i_en pattern 1,0,0,1,...: o_valid SHALL be high only after enabled cycles, and the samples SHALL match the continuous run of REQ-030.
REQ-033 Reset asserted at phase 2 of the 8th symbol: the next enabled cycle SHALL give o_sample 0, the PRBS SHALL restart, and the first 9 o_bit values SHALL be 1 again.
REQ-034 Random i_en over 2000 cycles versus the reference model of REQ-014..REQ-020: all valid samples SHALL match exactly.
